rs_stream_encoder: RTL and testbench

Streaming, parameterised systematic Reed-Solomon encoder over GF(2^SYM_W). It accepts one message symbol per cycle on a valid/ready stream and passes it through unchanged. After the last message symbol it appends 2T parity symbols computed by an LFSR division by g(x) = ∏(x − α^(FCR+i)), i = 0..2T−1. Shortened frames are supported on the fly. It is the streaming successor to the fixed RS(68,64) parallel parity generator and sits between the framer and the line-side serialiser.

---
 rtl/rs_pkg.sv | 51 +++++
 rtl/rs_stream_encoder_if.sv | 26 ++
 rtl/rs_lfsr.sv | 57 +++++
 rtl/rs_stream_encoder.sv | 118 +++++++++++
 tb/tb_rs_stream_encoder.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared GF(2^m) arithmetic and types for the streaming Reed-Solomon encoder.
// Field math is done on 16-bit containers so one function serves every width 3..12.
package rs_pkg;

   localparam int RS_SYM_W_DEF     = 8;
   localparam int RS_PRIM_POLY_DEF = 'h11D;
   localparam int RS_MAX_NPAR      = 64;

   typedef enum logic {
      MSG = 1'b0,
      PAR = 1'b1
   } rs_state_t;

   // Shift-and-add multiply, reducing by poly each time the product overflows bit w.
   function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] poly, input int w);
      logic [15:0] p;
      logic [15:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 16; i++) begin
         if (i < w && ((b >> i) & 16'd1) != 16'd0) p = p ^ aa;
         aa = aa << 1;
         if (((aa >> w) & 16'd1) != 16'd0) aa = aa ^ poly;
      end
      return p;
   endfunction

   function automatic logic [15:0] gf_pow(input int e, input logic [15:0] poly, input int w);
      logic [15:0] x;
      x = 16'd1;
      for (int i = 0; i < e; i++) x = gf_mul(x, 16'd2, poly, w);
      return x;
   endfunction

   // Coefficient idx (ascending degree) of g(x) = prod (x - a^(fcr+j)); g[npar] = 1 is implicit.
   function automatic logic [15:0] gen_poly(input int idx, input int npar, input int fcr,
                                            input logic [15:0] poly, input int w);
      logic [RS_MAX_NPAR:0][15:0] g;
      logic [15:0]                root;
      g    = '0;
      g[0] = 16'd1;
      for (int j = 0; j < npar; j++) begin
         root = gf_pow(fcr + j, poly, w);
         for (int k = j + 1; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root, poly, w);
         g[0] = gf_mul(g[0], root, poly, w);
      end
      return g[idx];
   endfunction

endpackage

// File: rtl/rs_stream_encoder_if.sv
// Message-in / codeword-out stream bundle of the RS encoder.
// master = upstream framer + downstream serialiser side, slave = encoder side.
interface rs_stream_encoder_if #(
   parameter int SYM_W = 8
);
   logic [SYM_W-1:0] s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;
   logic [SYM_W-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic             m_parity;
   logic             err_len;

   modport master (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_valid, m_last, m_parity, err_len
   );

   modport slave (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_valid, m_last, m_parity, err_len
   );
endinterface

// File: rtl/rs_lfsr.sv
// Parity LFSR: divides the message by g(x) while feeding, then shifts parity out MSB-first.
// Generator coefficients are elaboration-time constants; no runtime tables.
module rs_lfsr
   import rs_pkg::*;
#(
   parameter int SYM_W     = RS_SYM_W_DEF,
   parameter int NPAR      = 4,
   parameter int PRIM_POLY = RS_PRIM_POLY_DEF,
   parameter int FCR       = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_feed,
   input  logic             en_shift,
   input  logic             clr,
   input  logic [SYM_W-1:0] d,
   output logic [SYM_W-1:0] r_top
);

   function automatic logic [NPAR-1:0][SYM_W-1:0] calc_gen();
      logic [NPAR-1:0][SYM_W-1:0] c;
      logic [15:0]                t;
      for (int i = 0; i < NPAR; i++) begin
         t    = gen_poly(i, NPAR, FCR, 16'(PRIM_POLY), SYM_W);
         c[i] = t[SYM_W-1:0];
      end
      return c;
   endfunction

   localparam logic [NPAR-1:0][SYM_W-1:0] GEN = calc_gen();

   function automatic logic [SYM_W-1:0] mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
      logic [15:0] p;
      p = gf_mul(16'(a), 16'(b), 16'(PRIM_POLY), SYM_W);
      return p[SYM_W-1:0];
   endfunction

   logic [SYM_W-1:0] r_par [NPAR];
   logic [SYM_W-1:0] w_fb;

   assign w_fb  = d ^ r_par[NPAR-1];
   assign r_top = r_par[NPAR-1];

   // clr wins over shift so the final parity load leaves a clean register for the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < NPAR; i++) r_par[i] <= '0;
      end else if (en_feed) begin
         r_par[0] <= mul(w_fb, GEN[0]);
         for (int i = 1; i < NPAR; i++) r_par[i] <= r_par[i-1] ^ mul(w_fb, GEN[i]);
      end else if (en_shift) begin
         r_par[0] <= '0;
         for (int i = 1; i < NPAR; i++) r_par[i] <= r_par[i-1];
      end
   end

endmodule

// File: rtl/rs_stream_encoder.sv
// Streaming systematic RS encoder: message symbols pass through, 2T parity symbols follow.
//   state | meaning
//   MSG   | accepting message symbols, passing them through and feeding the LFSR
//   PAR   | input stalled, shifting 2T parity symbols out of the LFSR
module rs_stream_encoder
   import rs_pkg::*;
#(
   parameter int SYM_W     = RS_SYM_W_DEF,
   parameter int PRIM_POLY = RS_PRIM_POLY_DEF,
   parameter int K         = 64,
   parameter int T         = 2,
   parameter int FCR       = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   rs_stream_encoder_if.slave bus
);

   localparam int NPAR = 2 * T;
   localparam int CW   = $clog2(K + 1);
   localparam int PW   = $clog2(NPAR + 1);

   rs_state_t        r_state;
   logic [CW-1:0]    r_msg_cnt;
   logic [PW-1:0]    r_par_cnt;
   logic [SYM_W-1:0] r_m_data;
   logic             r_m_valid;
   logic             r_m_last;
   logic             r_m_parity;
   logic             r_err_len;

   logic             w_out_free;
   logic             w_s_ready;
   logic             w_accept;
   logic             w_par_load;
   logic             w_par_done;
   logic             w_cnt_hit;
   logic [SYM_W-1:0] w_r_top;

   assign w_out_free = !r_m_valid || bus.m_ready;
   assign w_s_ready  = (r_state == MSG) && w_out_free;
   assign w_accept   = bus.s_valid && w_s_ready;
   assign w_par_load = (r_state == PAR) && w_out_free;
   assign w_par_done = w_par_load && (r_par_cnt == PW'(NPAR - 1));
   assign w_cnt_hit  = (r_msg_cnt == CW'(K - 1));

   assign bus.s_ready  = w_s_ready;
   assign bus.m_data   = r_m_data;
   assign bus.m_valid  = r_m_valid;
   assign bus.m_last   = r_m_last;
   assign bus.m_parity = r_m_parity;
   assign bus.err_len  = r_err_len;

   rs_lfsr #(
      .SYM_W     (SYM_W),
      .NPAR      (NPAR),
      .PRIM_POLY (PRIM_POLY),
      .FCR       (FCR)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_feed  (w_accept),
      .en_shift (w_par_load),
      .clr      (w_par_done),
      .d        (bus.s_data),
      .r_top    (w_r_top)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= MSG;
         r_msg_cnt  <= '0;
         r_par_cnt  <= '0;
         r_m_data   <= '0;
         r_m_valid  <= 1'b0;
         r_m_last   <= 1'b0;
         r_m_parity <= 1'b0;
         r_err_len  <= 1'b0;
      end else begin
         r_err_len <= 1'b0;
         case (r_state)
            MSG: begin
               if (w_accept) begin
                  r_m_data   <= bus.s_data;
                  r_m_valid  <= 1'b1;
                  r_m_last   <= 1'b0;
                  r_m_parity <= 1'b0;
                  r_msg_cnt  <= r_msg_cnt + CW'(1);
                  if (bus.s_last || w_cnt_hit) begin
                     r_state   <= PAR;
                     r_err_len <= !bus.s_last;
                  end
               end else if (bus.m_ready) begin
                  r_m_valid <= 1'b0;
               end
            end
            PAR: begin
               // Output register is always refilled here, so m_valid never drops mid-parity.
               if (w_out_free) begin
                  r_m_data   <= w_r_top;
                  r_m_valid  <= 1'b1;
                  r_m_parity <= 1'b1;
                  r_m_last   <= 1'b0;
                  r_par_cnt  <= r_par_cnt + PW'(1);
                  if (w_par_done) begin
                     r_m_last  <= 1'b1;
                     r_par_cnt <= '0;
                     r_msg_cnt <= '0;
                     r_state   <= MSG;
                  end
               end
            end
            default: r_state <= MSG;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder: default RS(68,64) instance plus a T=8, FCR=1 instance.
module tb_rs_stream_encoder;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       l;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rs_stream_encoder_if #(.SYM_W(8)) bus0 ();
   rs_stream_encoder_if #(.SYM_W(8)) bus1 ();

   rs_stream_encoder #(.SYM_W(8), .PRIM_POLY('h11D), .K(64), .T(2), .FCR(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   rs_stream_encoder #(.SYM_W(8), .PRIM_POLY('h11D), .K(64), .T(8), .FCR(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic [7:0] sd [2];
   logic       sv [2];
   logic       sl [2];
   logic       mr [2] = '{1'b1, 1'b1};
   logic [7:0] md [2];
   logic       mv [2], ml [2], mp [2], srdy [2], el [2];

   assign bus0.s_data  = sd[0];
   assign bus0.s_valid = sv[0];
   assign bus0.s_last  = sl[0];
   assign bus0.m_ready = mr[0];
   assign bus1.s_data  = sd[1];
   assign bus1.s_valid = sv[1];
   assign bus1.s_last  = sl[1];
   assign bus1.m_ready = mr[1];
   assign md[0] = bus0.m_data;   assign md[1] = bus1.m_data;
   assign mv[0] = bus0.m_valid;  assign mv[1] = bus1.m_valid;
   assign ml[0] = bus0.m_last;   assign ml[1] = bus1.m_last;
   assign mp[0] = bus0.m_parity; assign mp[1] = bus1.m_parity;
   assign srdy[0] = bus0.s_ready; assign srdy[1] = bus1.s_ready;
   assign el[0] = bus0.err_len;  assign el[1] = bus1.err_len;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   bp [2] = '{1'b0, 1'b0};
   bit   ign_par0 = 1'b0;
   bit   new_frame0 = 1'b1;
   int   start0 = 0, last_end0 = 0, span0 = -1, gap0 = -1, errcnt0 = 0;
   bit   hold_prev [2] = '{1'b0, 1'b0};
   logic [9:0] prev_out [2];

   always @(posedge clk) cyc++;

   // Backpressure pattern changes just after each edge so it is stable at sampling time.
   always begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) mr[u] = bp[u] ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int u, input int d, input bit p, input bit l);
      exp_t e;
      e.d = 8'(d);
      e.p = p;
      e.l = l;
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Reference GF(256) multiply, Horner form over b from the MSB down.
   function automatic int tmul(input int a, input int b);
      int p = 0;
      for (int i = 7; i >= 0; i--) begin
         p = p << 1;
         if ((p & 'h100) != 0) p = p ^ 'h11D;
         if (((b >> i) & 1) != 0) p = p ^ a;
      end
      return p;
   endfunction

   function automatic int tpow(input int e);
      int x = 1;
      repeat (e) x = tmul(x, 2);
      return x;
   endfunction

   // Long division of m(x)*x^npar by g(x), coefficients held highest-degree first.
   task automatic push_model(input int u, input int msg[$]);
      int npar, fcr, r;
      int gd[$];
      int nw[$];
      int bq[$];
      npar = (u == 0) ? 4 : 16;
      fcr  = (u == 0) ? 0 : 1;
      gd = '{1};
      for (int j = 0; j < npar; j++) begin
         r  = tpow(fcr + j);
         nw = {};
         for (int k = 0; k <= gd.size(); k++) begin
            int a, b;
            a = (k < gd.size()) ? gd[k] : 0;
            b = (k > 0) ? tmul(gd[k-1], r) : 0;
            nw.push_back(a ^ b);
         end
         gd = nw;
      end
      bq = msg;
      repeat (npar) bq.push_back(0);
      for (int i = 0; i < msg.size(); i++) begin
         int c;
         c = bq[i];
         if (c != 0)
            for (int j = 1; j <= npar; j++) bq[i+j] = bq[i+j] ^ tmul(c, gd[j]);
      end
      for (int j = 0; j < npar; j++) push(u, bq[msg.size()+j], 1'b1, j == npar - 1);
   endtask

   // Called at posedge+1; returns at posedge+1 after the final symbol is accepted.
   task automatic send_frame(input int u, input int msg[$], input bit use_last);
      int n;
      for (int i = 0; i < msg.size(); i++) begin
         sd[u] = 8'(msg[i]);
         sv[u] = 1'b1;
         sl[u] = use_last && (i == msg.size() - 1);
         n = 0;
         @(negedge clk);
         while (!srdy[u] && n < 2000) begin
            @(negedge clk);
            n++;
         end
         if (!srdy[u]) begin
            check(srdy[u], "s_ready_timeout", 0, 1);
            sv[u] = 1'b0;
            sl[u] = 1'b0;
            return;
         end
         push(u, msg[i], 1'b0, 1'b0);
         @(posedge clk);
         #1;
      end
      sv[u] = 1'b0;
      sl[u] = 1'b0;
   endtask

   task automatic drain(input int u);
      int n = 0;
      while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(((u == 0) ? q0.size() : q1.size()) == 0, "drain_empty",
            (u == 0) ? q0.size() : q1.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic mon(input int u);
      exp_t       e;
      logic [9:0] cur;
      cur = {md[u], mp[u], ml[u]};
      if (hold_prev[u]) begin
         check(mv[u], "valid_held", 32'(mv[u]), 1);
         if (mv[u]) check(cur == prev_out[u], "out_stable", 32'(cur), 32'(prev_out[u]));
      end
      if (mv[u] && mr[u] && !(u == 0 && ign_par0 && mp[u])) begin
         if (((u == 0) ? q0.size() : q1.size()) == 0) begin
            check(((u == 0) ? q0.size() : q1.size()) != 0, "unexpected_output", 32'(cur), 0);
         end else begin
            if (u == 0) begin
               e = q0.pop_front();
               check(cur == {e.d, e.p, e.l}, "dut0_out", 32'(cur), 32'({e.d, e.p, e.l}));
            end else begin
               e = q1.pop_front();
               check(cur == {e.d, e.p, e.l}, "dut1_out", 32'(cur), 32'({e.d, e.p, e.l}));
            end
         end
         if (u == 0) begin
            if (new_frame0) begin
               gap0       = cyc - last_end0;
               start0     = cyc;
               new_frame0 = 1'b0;
            end
            if (ml[0]) begin
               span0      = cyc - start0;
               last_end0  = cyc;
               new_frame0 = 1'b1;
            end
         end
      end
      hold_prev[u] = mv[u] && !mr[u];
      prev_out[u]  = cur;
      if (u == 0 && el[0]) errcnt0++;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         new_frame0   = 1'b1;
         hold_prev[0] = 1'b0;
         hold_prev[1] = 1'b0;
      end else begin
         for (int u = 0; u < 2; u++) mon(u);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m[$];
      int m10[$];
      int m5[$];
      int full[$];
      int n;
      bit bad;
      for (int u = 0; u < 2; u++) begin
         sd[u] = '0;
         sv[u] = 1'b0;
         sl[u] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check(mv[0] == 1'b0, "rst_m_valid", 32'(mv[0]), 0);
      check(md[0] == 8'h00, "rst_m_data", 32'(md[0]), 0);
      check({ml[0], mp[0], el[0]} == 3'b000, "rst_flags", 32'({ml[0], mp[0], el[0]}), 0);
      check(srdy[0] == 1'b1, "rst_s_ready", 32'(srdy[0]), 1);
      check(mv[1] == 1'b0 && srdy[1] == 1'b1, "rst_dut1", 32'({mv[1], srdy[1]}), 1);
      @(posedge clk);
      #1;

      // Single 1 in the lowest-degree position: parity is g(x) minus its leading term.
      m = {};
      repeat (63) m.push_back(0);
      m.push_back(1);
      send_frame(0, m, 1'b1);
      check(el[0] == 1'b0, "err_len_with_last", 32'(el[0]), 0);
      push(0, 15, 1'b1, 1'b0);
      push(0, 54, 1'b1, 1'b0);
      push(0, 120, 1'b1, 1'b0);
      push(0, 64, 1'b1, 1'b1);
      drain(0);
      check(span0 == 67, "frame_span_68", span0, 67);

      bp[0] = 1'b1;
      send_frame(0, m, 1'b1);
      push(0, 15, 1'b1, 1'b0);
      push(0, 54, 1'b1, 1'b0);
      push(0, 120, 1'b1, 1'b0);
      push(0, 64, 1'b1, 1'b1);
      drain(0);
      bp[0] = 1'b0;
      @(posedge clk);
      #1;

      // Shortened frame followed back to back by another frame.
      m10 = {};
      repeat (10) m10.push_back(int'($urandom_range(0, 255)));
      m5 = {};
      repeat (5) m5.push_back(int'($urandom_range(0, 255)));
      send_frame(0, m10, 1'b1);
      check(el[0] == 1'b0, "err_len_short", 32'(el[0]), 0);
      full = {};
      repeat (54) full.push_back(0);
      foreach (m10[i]) full.push_back(m10[i]);
      push_model(0, full);
      send_frame(0, m5, 1'b1);
      push_model(0, m5);
      drain(0);
      check(gap0 == 1, "back_to_back_gap", gap0, 1);
      check(span0 == 8, "short_frame_span", span0, 8);

      // K symbols with no s_last: length error, parity still appended.
      m = {};
      for (int i = 0; i < 64; i++) m.push_back((i * 37 + 11) & 255);
      send_frame(0, m, 1'b0);
      check(el[0] == 1'b1, "err_len_pulse", 32'(el[0]), 1);
      push_model(0, m);
      bad = 1'b0;
      n = 0;
      while (!(mv[0] && ml[0]) && n < 100) begin
         @(negedge clk);
         if (!(mv[0] && ml[0]) && srdy[0]) bad = 1'b1;
         n++;
      end
      check(!bad, "s_ready_low_in_par", 32'(bad), 0);
      check(n < 100, "par_end_reached", n, 100);
      @(posedge clk);
      #1;
      drain(0);
      check(errcnt0 == 1, "err_len_count", errcnt0, 1);

      // Reset while parity is being emitted.
      ign_par0 = 1'b1;
      m = {};
      for (int i = 0; i < 64; i++) m.push_back(i + 1);
      send_frame(0, m, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check(mv[0] == 1'b0, "valid_after_midreset", 32'(mv[0]), 0);
      check(ml[0] == 1'b0 && mp[0] == 1'b0, "flags_after_midreset", 32'({ml[0], mp[0]}), 0);
      ign_par0 = 1'b0;
      @(posedge clk);
      #1;
      m = {};
      repeat (64) m.push_back(0);
      send_frame(0, m, 1'b1);
      push(0, 0, 1'b1, 1'b0);
      push(0, 0, 1'b1, 1'b0);
      push(0, 0, 1'b1, 1'b0);
      push(0, 0, 1'b1, 1'b1);
      drain(0);

      // T = 8, FCR = 1 instance: random frames under random backpressure.
      bp[1] = 1'b1;
      for (int f = 0; f < 120; f++) begin
         int len;
         len = int'($urandom_range(1, 64));
         m = {};
         repeat (len) m.push_back(int'($urandom_range(0, 255)));
         send_frame(1, m, 1'b1);
         push_model(1, m);
      end
      drain(1);
      bp[1] = 1'b0;

      repeat (4) @(posedge clk);
      check(q0.size() == 0 && q1.size() == 0, "final_queues_empty", q0.size() + q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
